// File: rtl/dec_trace_serializer.sv
// Retirement trace serializer: buffers 3-lane trace packets and emits one record per valid lane.
// Optional RV_TRACE_DROP_EN: never backpressure; drop packets when full and tag the next entry with ovf.
package dec_trace_pkg;
  typedef struct packed {
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } trace_pkt_t;
endpackage

module dec_trace_serializer
  import dec_trace_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  trace_pkt_t  trace_in,
  output logic        trace_in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_addr,
  output logic [31:0] out_tval,
  output logic [4:0]  out_ecause,
  output logic        out_exception,
  output logic        out_interrupt,
  output logic [1:0]  out_lane,
  output logic        out_last,
  output logic        out_ovf,
  output logic [15:0] drop_cnt
);

`ifdef RV_TRACE_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  trace_pkt_t            mem_q [DEPTH];
  trace_pkt_t            mem_d [DEPTH];
  logic [DEPTH-1:0][2:0] mask_q, mask_d;
  logic [DEPTH-1:0]      ovf_q, ovf_d;
  logic                  pend_q, pend_d;
  logic [15:0]           drop_q, drop_d;

  trace_pkt_t  head;
  logic [2:0]  hmask, lsb;
  logic [1:0]  lane;
  logic        last, hs, pop, push, drop, present, full, full_eff, exc, irq;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign hmask   = mask_q[rd_ptr_q];
  assign lsb     = hmask & (~hmask + 3'd1);
  assign lane    = lsb[0] ? 2'd0 : (lsb[1] ? 2'd1 : 2'd2);
  assign last    = (hmask & ~lsb) == 3'b000;
  assign present = |trace_in.trace_rv_i_valid_ip;
  assign full    = (cnt_q == CW'(DEPTH));

  assign out_valid = (cnt_q != '0);
  assign hs        = out_valid & out_ready;
  assign pop       = hs & last;
  // In drop mode a popping full FIFO still takes the new packet.
  assign full_eff  = full & ~pop;
  assign trace_in_ready = DROP_EN ? 1'b1 : ~full;
  assign push      = present & (DROP_EN ? ~full_eff : ~full);
  assign drop      = DROP_EN & present & full_eff;

  assign exc = head.trace_rv_i_exception_ip[lane];
  assign irq = head.trace_rv_i_interrupt_ip[lane];

  assign out_insn      = out_valid ? head.trace_rv_i_insn_ip[{lane, 5'b0} +: 32] : '0;
  assign out_addr      = out_valid ? head.trace_rv_i_address_ip[{lane, 5'b0} +: 32] : '0;
  assign out_exception = out_valid & exc;
  assign out_interrupt = out_valid & irq;
  assign out_tval      = (out_valid & (exc | irq)) ? head.trace_rv_i_tval_ip : '0;
  assign out_ecause    = (out_valid & (exc | irq)) ? head.trace_rv_i_ecause_ip : '0;
  assign out_lane      = out_valid ? lane : 2'd0;
  assign out_last      = out_valid & last;
  assign out_ovf       = DROP_EN & out_valid & ovf_q[rd_ptr_q];
  assign drop_cnt      = drop_q;

  always_comb begin
    mem_d    = mem_q;
    mask_d   = mask_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Handshake update first so a same-cycle push into the freed slot wins.
    if (hs) begin
      mask_d[rd_ptr_q] = hmask & ~lsb;
      ovf_d[rd_ptr_q]  = 1'b0;
    end
    if (pop) rd_ptr_d = inc(rd_ptr_q);
    if (push) begin
      mem_d[wr_ptr_q]  = trace_in;
      mask_d[wr_ptr_q] = trace_in.trace_rv_i_valid_ip;
      ovf_d[wr_ptr_q]  = pend_q;
      pend_d           = 1'b0;
      wr_ptr_d         = inc(wr_ptr_q);
    end
    if (drop) begin
      pend_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      ovf_q    <= '0;
      pend_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage needs no reset; occupancy and masks gate its visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dec_trace_serializer.sv
// Directed bench for dec_trace_serializer (DEPTH=2); drop-mode steps enabled by RV_TRACE_DROP_EN.
module tb_dec_trace_serializer;
  import dec_trace_pkg::*;

  logic        clk, rst_l, trace_in_ready, out_valid, out_ready;
  trace_pkt_t  trace_in;
  logic [31:0] out_insn, out_addr, out_tval;
  logic [4:0]  out_ecause;
  logic        out_exception, out_interrupt, out_last, out_ovf;
  logic [1:0]  out_lane;
  logic [15:0] drop_cnt;
  int          total, bad;

  dec_trace_serializer #(.DEPTH(2)) dut (
    .clk(clk), .rst_l(rst_l), .trace_in(trace_in), .trace_in_ready(trace_in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_addr(out_addr),
    .out_tval(out_tval), .out_ecause(out_ecause), .out_exception(out_exception),
    .out_interrupt(out_interrupt), .out_lane(out_lane), .out_last(out_last),
    .out_ovf(out_ovf), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic trace_pkt_t mk(input logic [2:0] v, input logic [2:0] ex, input logic [2:0] ir,
                                    input logic [4:0] ec, input logic [31:0] tv, input logic [31:0] base);
    trace_pkt_t p;
    p = '0;
    p.trace_rv_i_insn_ip    = {base + 32'd2, base + 32'd1, base};
    p.trace_rv_i_address_ip = {32'h1008, 32'h1004, 32'h1000};
    p.trace_rv_i_valid_ip     = v;
    p.trace_rv_i_exception_ip = ex;
    p.trace_rv_i_interrupt_ip = ir;
    p.trace_rv_i_ecause_ip    = ec;
    p.trace_rv_i_tval_ip      = tv;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_l = 1'b0; out_ready = 1'b0; trace_in = '0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(trace_in_ready), 1);
    chk("rst_insn", out_insn, 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    @(negedge clk) rst_l = 1'b1;

    // Sparse lanes 0 and 2; ecause/tval must be masked without exception.
    out_ready = 1'b1;
    trace_in = mk(3'b101, 3'b000, 3'b000, 5'd5, 32'h1234, 32'hA0);
    tick;
    trace_in = '0;
    chk("sp0_valid", 32'(out_valid), 1);
    chk("sp0_lane", 32'(out_lane), 0);
    chk("sp0_insn", out_insn, 32'hA0);
    chk("sp0_last", 32'(out_last), 0);
    chk("sp0_ecause", 32'(out_ecause), 0);
    chk("sp0_tval", out_tval, 0);
    tick;
    chk("sp2_lane", 32'(out_lane), 2);
    chk("sp2_insn", out_insn, 32'hA2);
    chk("sp2_addr", out_addr, 32'h1008);
    chk("sp2_last", 32'(out_last), 1);
    tick;
    chk("sp_popped", 32'(out_valid), 0);

    // Exception on lane 1.
    trace_in = mk(3'b010, 3'b010, 3'b000, 5'd2, 32'hDEADBEEF, 32'hB0);
    tick;
    trace_in = '0;
    chk("ex_lane", 32'(out_lane), 1);
    chk("ex_exc", 32'(out_exception), 1);
    chk("ex_irq", 32'(out_interrupt), 0);
    chk("ex_ecause", 32'(out_ecause), 2);
    chk("ex_tval", out_tval, 32'hDEADBEEF);
    chk("ex_last", 32'(out_last), 1);
    chk("ex_ovf", 32'(out_ovf), 0);
    tick;
    chk("ex_popped", 32'(out_valid), 0);

`ifndef RV_TRACE_DROP_EN
    // Backpressure: two pushes fill DEPTH=2, third waits; records held stable.
    out_ready = 1'b0;
    trace_in = mk(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h100);
    tick;
    chk("bp1_ready", 32'(trace_in_ready), 1);
    chk("bp1_insn", out_insn, 32'h100);
    trace_in = mk(3'b011, 3'b000, 3'b000, 5'd0, 32'h0, 32'h200);
    tick;
    chk("bp2_ready", 32'(trace_in_ready), 0);
    chk("bp2_insn", out_insn, 32'h100);
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h300);
    tick;
    chk("bp3_ready", 32'(trace_in_ready), 0);
    chk("bp3_insn", out_insn, 32'h100);
    chk("bp3_lane", 32'(out_lane), 0);
    out_ready = 1'b1;
    tick;
    chk("dr1_insn", out_insn, 32'h101);
    chk("dr1_ready", 32'(trace_in_ready), 0);
    tick;
    chk("dr2_insn", out_insn, 32'h102);
    chk("dr2_last", 32'(out_last), 1);
    tick;
    chk("dr3_insn", out_insn, 32'h200);
    chk("dr3_ready", 32'(trace_in_ready), 1);
    tick;
    trace_in = '0;
    chk("dr4_insn", out_insn, 32'h201);
    chk("dr4_last", 32'(out_last), 1);
    tick;
    chk("dr5_insn", out_insn, 32'h300);
    chk("dr5_last", 32'(out_last), 1);
    tick;
    chk("dr_empty", 32'(out_valid), 0);
    chk("dr_drop", 32'(drop_cnt), 0);
`else
    // Drop mode: fill, drop three, drain, then next packet carries ovf.
    out_ready = 1'b0;
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h800);
    tick;
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h900);
    tick;
    trace_in = mk(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'hF00);
    for (int i = 0; i < 3; i++) tick;
    trace_in = '0;
    chk("dp_drop", 32'(drop_cnt), 3);
    chk("dp_ready", 32'(trace_in_ready), 1);
    chk("dp_head_ovf", 32'(out_ovf), 0);
    out_ready = 1'b1;
    tick;
    chk("dp_d2_insn", out_insn, 32'h900);
    tick;
    chk("dp_empty", 32'(out_valid), 0);
    trace_in = mk(3'b011, 3'b000, 3'b000, 5'd0, 32'h0, 32'hA00);
    tick;
    trace_in = '0;
    chk("dp_t0_insn", out_insn, 32'hA00);
    chk("dp_t0_ovf", 32'(out_ovf), 1);
    tick;
    chk("dp_t1_insn", out_insn, 32'hA01);
    chk("dp_t1_ovf", 32'(out_ovf), 0);
    tick;
    // Full FIFO popping while a packet arrives: accepted, not dropped.
    out_ready = 1'b0;
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'hB00);
    tick;
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'hC00);
    tick;
    out_ready = 1'b1;
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'hD00);
    tick;
    trace_in = '0;
    chk("fp_insn", out_insn, 32'hC00);
    chk("fp_drop", 32'(drop_cnt), 3);
    tick;
    chk("fp_wrap_insn", out_insn, 32'hD00);
    chk("fp_wrap_ovf", 32'(out_ovf), 0);
    tick;
    chk("fp_empty", 32'(out_valid), 0);
`endif

    // Push+pop at occupancy 1 keeps occupancy; order survives pointer wrap.
    out_ready = 1'b0;
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h400);
    tick;
    chk("pp1_insn", out_insn, 32'h400);
    out_ready = 1'b1;
    trace_in = mk(3'b100, 3'b000, 3'b100, 5'd7, 32'h77, 32'h500);
    tick;
    chk("pp2_insn", out_insn, 32'h502);
    chk("pp2_irq", 32'(out_interrupt), 1);
    chk("pp2_ecause", 32'(out_ecause), 7);
    chk("pp2_ready", 32'(trace_in_ready), 1);
    trace_in = mk(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h600);
    tick;
    trace_in = '0;
    chk("pp3_insn", out_insn, 32'h600);
    tick;
    chk("pp_empty", 32'(out_valid), 0);

    // Reset while lane 1 of a 3-lane packet is pending.
    trace_in = mk(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h700);
    tick;
    trace_in = '0;
    tick;
    chk("rs_pending_insn", out_insn, 32'h701);
    #1 rst_l = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_insn", out_insn, 0);
    chk("rs_ready", 32'(trace_in_ready), 1);
    @(negedge clk) rst_l = 1'b1;
    tick;
    tick;
    chk("rs_no_stale", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec_trace_serializer.md
DEC_TRACE_SERIALIZER -- requirements
Module: dec_trace_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of whole trace_pkt_t packets buffered (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst_l, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port trace_in, input, trace_pkt_t, the 3-lane retirement trace packet; a packet is present when trace_rv_i_valid_ip != 0.
REQ-005 SHALL have port trace_in_ready, output, 1, high when a present packet is accepted this cycle.
REQ-006 SHALL have port out_valid, output, 1, high when a single-instruction record is offered.
REQ-007 SHALL have port out_ready, input, 1, sink accepts the record.
REQ-008 SHALL have ports out_insn [31:0], out_addr [31:0], out_tval [31:0], out_ecause [4:0], out_exception 1, out_interrupt 1, out_lane [1:0], out_last 1 and out_ovf 1, all outputs, forming the record.
REQ-009 SHALL have port drop_cnt, output, 16, the count of dropped packets.

Function
REQ-010 SHALL accept a packet when present and trace_in_ready are both high; zero-valid packets SHALL be ignored and SHALL NOT occupy an entry.
REQ-011 SHALL compute trace_in_ready from registered occupancy only (count < DEPTH), with no combinational path from out_ready.
REQ-012 SHALL store accepted packets in a circular FIFO; the read and write pointers SHALL wrap modulo DEPTH.
REQ-013 SHALL drive out_valid whenever the FIFO is non-empty; the first record of a packet accepted in cycle N SHALL be offered in cycle N+1 at the earliest.
REQ-014 SHALL emit the valid lanes of the head packet in ascending lane order (0,1,2) and skip invalid lanes; one record SHALL be emitted per out_valid & out_ready cycle.
REQ-015 SHALL take lane k data from insn/address bits [32k+31:32k], out_exception from exception_ip[k] and out_interrupt from interrupt_ip[k].
REQ-016 SHALL drive out_ecause and out_tval from the packet only on a record whose exception or interrupt bit is set; otherwise both SHALL be 0.
REQ-017 SHALL assert out_last on the highest valid lane, and SHALL pop the entry on that record's handshake.
REQ-018 SHALL hold every record output stable while out_valid & !out_ready.
REQ-019 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged.
REQ-020 SHALL keep a per-entry lane-pending mask, loaded with valid_ip on push; handshakes clear the lowest set bit.

Reset
REQ-021 SHALL, with rst_l low, asynchronously clear the pointers, occupancy, lane masks, ovf flags, drop_cnt and the pending-overflow flag.
REQ-022 SHALL drive out_valid=0, trace_in_ready=1 and all record outputs and drop_cnt to 0 during reset.
REQ-023 SHALL discard all buffered packets, including any partially emitted packet, when reset is asserted mid-operation.

Configuration
REQ-024 SHALL use macro RV_TRACE_DROP_EN.
REQ-025 SHALL, with RV_TRACE_DROP_EN defined, hold trace_in_ready constant 1.
REQ-026 SHALL, with RV_TRACE_DROP_EN defined, handle a present packet arriving while full with no same-cycle pop as follows: drop it, increment drop_cnt saturating at 0xFFFF, and set the pending-overflow flag.
REQ-027 SHALL, with RV_TRACE_DROP_EN defined, tag the next pushed packet's entry with ovf=1 and clear the pending flag.
REQ-028 SHALL, with RV_TRACE_DROP_EN defined, drive out_ovf=1 only on the first record of a tagged entry.
REQ-029 SHALL, with RV_TRACE_DROP_EN defined, count a full FIFO that pops in the same cycle as not full.
REQ-030 SHALL, without RV_TRACE_DROP_EN, backpressure per REQ-011 and tie drop_cnt and out_ovf to 0.

Verification
REQ-031 SHALL cover: valid_ip=3'b101, insn={C,B,A}, out_ready=1 -> two records: lane0 insn A last=0, then lane2 insn C last=1; entry popped.
REQ-032 SHALL cover: valid_ip=3'b010, exception_ip=3'b010, ecause=5'd2, tval=0xDEAD_BEEF -> one record with lane=1, exception=1, ecause=2, tval=0xDEADBEEF, last=1.
REQ-033 SHALL cover: DEPTH=2, out_ready=0, three consecutive packets -> without the macro, trace_in_ready=0 after two pushes and records stay stable; releasing out_ready then drains all records in order.
REQ-034 SHALL cover: RV_TRACE_DROP_EN with FIFO full, 3 packets then 1 more after a drain -> drop_cnt=3, and the first record of the later packet has out_ovf=1 and subsequent records 0.
REQ-035 SHALL cover: a full FIFO with a last-record handshake and a new packet in the same cycle -> packet accepted, occupancy stays DEPTH, pointers wrap correctly.
REQ-036 SHALL cover: rst_l dropped while lane1 of a 3-lane packet is pending -> out_valid=0 immediately; no stale record appears after release.
